// File: rtl/fifo_stream_checker_pkg.sv
// Shared definitions for the AFIFO read-side stream checker.
// State codes are exposed as localparams so external code can decode state_q.
package fifo_stream_checker_pkg;

    localparam logic [1:0] ST_PRIME = 2'd0;
    localparam logic [1:0] ST_CHECK = 2'd1;
    localparam logic [1:0] ST_HALT  = 2'd2;

    typedef enum logic [1:0] {
        S_PRIME = ST_PRIME,
        S_CHECK = ST_CHECK,
        S_HALT  = ST_HALT
    } state_t;

endpackage

// File: rtl/fifo_stream_checker_sat_counter.sv
// Saturating up-counter with synchronous clear; a clear and an increment
// on the same edge leave the count at one.
module sat_counter #(
    parameter int WIDTH = 8
) (
    input  logic             clk_i,
    input  logic             rst_n_i,
    input  logic             inc_i,
    input  logic             clr_i,
    output logic [WIDTH-1:0] count_o
);

    logic [WIDTH-1:0] count_q, count_d;

    always_comb begin
        count_d = clr_i ? '0 : count_q;
        if (inc_i && (count_d != '1)) begin
            count_d = count_d + WIDTH'(1);
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count_o = count_q;

endmodule

// File: rtl/fifo_stream_checker.sv
// Drains the AFIFO read port and checks the stream is a contiguous
// incrementing count, keeping word/error counts and first/last mismatch details.
//
// state  | meaning
// PRIME  | waiting for a baseline word; no comparison
// CHECK  | each accepted word must equal previous + 1 (mod 2^W)
// HALT   | draining stopped after a mismatch; only resync leaves
module fifo_stream_checker
    import fifo_stream_checker_pkg::*;
#(
    parameter int W           = 16,
    parameter int ERR_W       = 8,
    parameter bit STOP_ON_ERR = 1'b0
) (
    input  logic             clk_i,
    input  logic             rst_n_i,
    input  logic             en_i,
    input  logic             resync_i,
    input  logic             err_clr_i,
    output logic             fifo_trigger_o,
    input  logic [W-1:0]     fifo_data_i,
    input  logic             fifo_ready_i,
    output logic [31:0]      word_count_o,
    output logic [ERR_W-1:0] err_count_o,
    output logic             err_o,
    output logic             halted_o,
    output logic [W-1:0]     first_exp_o,
    output logic [W-1:0]     first_got_o,
    output logic [W-1:0]     last_exp_o,
    output logic [W-1:0]     last_got_o
);

    state_t        state_q, state_d;
    logic          trig_q, trig_d;
    logic          halted_q, halted_d;
    logic          err_q, err_d;
    logic [31:0]   word_count_q, word_count_d;
    logic [W-1:0]  last_q, last_d;
    logic [W-1:0]  first_exp_q, first_exp_d, first_got_q, first_got_d;
    logic [W-1:0]  last_exp_q, last_exp_d, last_got_q, last_got_d;

    logic          accept;
    logic          mismatch;
    logic [W-1:0]  exp_word;

    assign accept   = trig_q & fifo_ready_i;
    assign exp_word = last_q + W'(1);
    // A word accepted on the resync edge is counted but never compared.
    assign mismatch = accept && (state_q == S_CHECK) && !resync_i
                      && (fifo_data_i != exp_word);

    always_comb begin
        state_d      = state_q;
        last_d       = last_q;
        err_d        = err_q;
        first_exp_d  = first_exp_q;
        first_got_d  = first_got_q;
        last_exp_d   = last_exp_q;
        last_got_d   = last_got_q;
        word_count_d = word_count_q + {31'b0, accept};

        if (resync_i) begin
            state_d = S_PRIME;
        end else if (accept) begin
            case (state_q)
                S_PRIME: begin
                    last_d  = fifo_data_i;
                    state_d = S_CHECK;
                end
                S_CHECK: begin
                    last_d = fifo_data_i;
                    if (mismatch && STOP_ON_ERR) begin
                        state_d = S_HALT;
                    end
                end
                default: ;
            endcase
        end

        if (err_clr_i) begin
            err_d       = 1'b0;
            first_exp_d = '0;
            first_got_d = '0;
            last_exp_d  = '0;
            last_got_d  = '0;
        end
        // A mismatch on the clear edge wins and becomes the new first error.
        if (mismatch) begin
            err_d      = 1'b1;
            last_exp_d = exp_word;
            last_got_d = fifo_data_i;
            if (!err_q || err_clr_i) begin
                first_exp_d = exp_word;
                first_got_d = fifo_data_i;
            end
        end

        trig_d   = en_i && (state_d != S_HALT) && !resync_i;
        halted_d = (state_d == S_HALT);
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q      <= S_PRIME;
            trig_q       <= 1'b0;
            halted_q     <= 1'b0;
            err_q        <= 1'b0;
            word_count_q <= '0;
            last_q       <= '0;
            first_exp_q  <= '0;
            first_got_q  <= '0;
            last_exp_q   <= '0;
            last_got_q   <= '0;
        end else begin
            state_q      <= state_d;
            trig_q       <= trig_d;
            halted_q     <= halted_d;
            err_q        <= err_d;
            word_count_q <= word_count_d;
            last_q       <= last_d;
            first_exp_q  <= first_exp_d;
            first_got_q  <= first_got_d;
            last_exp_q   <= last_exp_d;
            last_got_q   <= last_got_d;
        end
    end

    sat_counter #(.WIDTH(ERR_W)) u_err_cnt (
        .clk_i   (clk_i),
        .rst_n_i (rst_n_i),
        .inc_i   (mismatch),
        .clr_i   (err_clr_i),
        .count_o (err_count_o)
    );

    assign fifo_trigger_o = trig_q;
    assign word_count_o   = word_count_q;
    assign err_o          = err_q;
    assign halted_o       = halted_q;
    assign first_exp_o    = first_exp_q;
    assign first_got_o    = first_got_q;
    assign last_exp_o     = last_exp_q;
    assign last_got_o     = last_got_q;

endmodule
